// File: rtl/gpr_pkg.sv
// Shared defaults and helpers for the general-purpose register file and its read ports.
package gpr_pkg;

    localparam int unsigned GprDataW   = 32;
    localparam int unsigned GprAddrW   = 5;
    localparam int unsigned GprNfwd    = 2;
    localparam int unsigned GprRegZero = 0;

    function automatic int unsigned byte_lanes(input int unsigned width);
        return width / 8;
    endfunction

endpackage

// File: rtl/gpr_rd_port.sv
// One read port: forwarding priority mux, write-back byte merge and hazard detection.
module gpr_rd_port
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W = GprDataW,
    parameter int unsigned ADDR_W = GprAddrW,
    parameter int unsigned NFWD   = GprNfwd
) (
    input  logic                     en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        rf_word,
    input  logic                     rf_busy,
    input  logic [DATA_W/8-1:0]      wb_be,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [NFWD*DATA_W/8-1:0] fwd_be,
    input  logic [NFWD*ADDR_W-1:0]   fwd_addr,
    input  logic [NFWD*DATA_W-1:0]   fwd_data,
    input  logic [NFWD-1:0]          fwd_nofwd,
    input  logic                     sb_clr,
    input  logic [ADDR_W-1:0]        sb_clr_addr,
    input  logic                     br_id,
    output logic [DATA_W-1:0]        data,
    output logic [DATA_W-1:0]        raw,
    output logic                     s0_hit,
    output logic                     stall
);

    localparam int unsigned NB = byte_lanes(DATA_W);

    logic [NFWD-1:0]   hit;
    logic [DATA_W-1:0] base;
    logic              is_zero;
    logic              fwd_stall;
    logic              busy_stall;

    always_comb begin
        for (int k = 0; k < int'(NFWD); k++) begin
            hit[k] = (|fwd_be[k*NB +: NB]) && (fwd_addr[k*ADDR_W +: ADDR_W] == addr);
        end
    end

    always_comb begin
        base = rf_word;
        if (wb_addr == addr) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wb_be[b]) base[b*8 +: 8] = wb_data[b*8 +: 8];
            end
        end
    end

    // Walk oldest to youngest so the youngest matching stage has the last word.
    always_comb begin
        data      = base;
        raw       = base;
        fwd_stall = 1'b0;
        for (int k = int'(NFWD) - 1; k >= 0; k--) begin
            if (hit[k]) begin
                data      = fwd_data[k*DATA_W +: DATA_W];
                fwd_stall = fwd_nofwd[k];
            end
        end
        for (int k = int'(NFWD) - 1; k >= 1; k--) begin
            if (hit[k]) raw = fwd_data[k*DATA_W +: DATA_W];
        end
        if (is_zero) begin
            data = '0;
            raw  = '0;
        end
    end

    assign is_zero    = (addr == ADDR_W'(GprRegZero));
    assign busy_stall = rf_busy && !(sb_clr && (sb_clr_addr == addr));
    assign s0_hit     = hit[0];
    assign stall      = en && !is_zero && (fwd_stall || busy_stall || (br_id && hit[0]));

endmodule

// File: rtl/gpr_file_sb.sv
// Register file with forwarding, byte-enable write-back, pending-write scoreboard,
// branch operand capture and a saturating stall counter.
module gpr_file_sb
    import gpr_pkg::*;
#(
    parameter int unsigned DATA_W = GprDataW,
    parameter int unsigned ADDR_W = GprAddrW,
    parameter int unsigned NRD    = 2,
    parameter int unsigned NFWD   = GprNfwd,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NRD-1:0]           rd_en,
    input  logic [NRD*ADDR_W-1:0]    rd_addr,
    output logic [NRD*DATA_W-1:0]    rd_data,
    output logic [NRD*DATA_W-1:0]    rd_raw,
    input  logic [DATA_W/8-1:0]      wb_be,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic [NFWD*DATA_W/8-1:0] fwd_be,
    input  logic [NFWD*ADDR_W-1:0]   fwd_addr,
    input  logic [NFWD*DATA_W-1:0]   fwd_data,
    input  logic [NFWD-1:0]          fwd_nofwd,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    input  logic                     sb_clr,
    input  logic [ADDR_W-1:0]        sb_clr_addr,
    input  logic                     br_id,
    output logic [NRD-1:0]           br_hold_vld,
    output logic [DATA_W-1:0]        br_hold_data,
    output logic                     stallreq,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int unsigned NREG = 2 ** ADDR_W;
    localparam int unsigned NB   = byte_lanes(DATA_W);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [NREG-1:0]   busy_q, busy_d;
    logic [NRD-1:0]    port_stall, port_s0;
    logic [NRD-1:0]    hold_vld_q;
    logic [DATA_W-1:0] hold_data_q;
    logic [CNT_W-1:0]  cnt_q;

    for (genvar p = 0; p < NRD; p++) begin : g_port
        gpr_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NFWD   (NFWD)
        ) u_port (
            .en          (rd_en[p]),
            .addr        (rd_addr[p*ADDR_W +: ADDR_W]),
            .rf_word     (mem_q[rd_addr[p*ADDR_W +: ADDR_W]]),
            .rf_busy     (busy_q[rd_addr[p*ADDR_W +: ADDR_W]]),
            .wb_be       (wb_be),
            .wb_addr     (wb_addr),
            .wb_data     (wb_data),
            .fwd_be      (fwd_be),
            .fwd_addr    (fwd_addr),
            .fwd_data    (fwd_data),
            .fwd_nofwd   (fwd_nofwd),
            .sb_clr      (sb_clr),
            .sb_clr_addr (sb_clr_addr),
            .br_id       (br_id),
            .data        (rd_data[p*DATA_W +: DATA_W]),
            .raw         (rd_raw[p*DATA_W +: DATA_W]),
            .s0_hit      (port_s0[p]),
            .stall       (port_stall[p])
        );
    end

    assign stallreq = |port_stall;

    // Set is applied after clear so a same-cycle set/clear leaves the register pending.
    always_comb begin
        busy_d = busy_q;
        if (sb_clr) busy_d[sb_clr_addr] = 1'b0;
        if (sb_set) busy_d[sb_set_addr] = 1'b1;
        busy_d[GprRegZero] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) mem_q[i] <= '0;
        end else if (wb_addr != ADDR_W'(GprRegZero)) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wb_be[b]) mem_q[wb_addr][b*8 +: 8] <= wb_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= '0;
            hold_vld_q  <= '0;
            hold_data_q <= '0;
            cnt_q       <= '0;
        end else begin
            busy_q      <= busy_d;
            hold_vld_q  <= port_s0 & {NRD{br_id}};
            hold_data_q <= fwd_data[DATA_W-1:0];
            if (stallreq && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign br_hold_vld  = hold_vld_q;
    assign br_hold_data = hold_data_q;
    assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_gpr_file_sb.sv
// Directed table plus randomized run of gpr_file_sb against a behavioural model.
module tb_gpr_file_sb;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NF = 2;
    localparam int CW = 8;

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data, rd_raw;
    logic [3:0]      wb_be;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [NF*4-1:0] fwd_be;
    logic [NF*AW-1:0] fwd_addr;
    logic [NF*DW-1:0] fwd_data;
    logic [NF-1:0]   fwd_nofwd;
    logic            sb_set, sb_clr;
    logic [AW-1:0]   sb_set_addr, sb_clr_addr;
    logic            br_id;
    logic [NR-1:0]   br_hold_vld;
    logic [DW-1:0]   br_hold_data;
    logic            stallreq;
    logic [CW-1:0]   stall_cnt;

    gpr_file_sb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NRD    (NR),
        .NFWD   (NF),
        .CNT_W  (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_raw       (rd_raw),
        .wb_be        (wb_be),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .fwd_be       (fwd_be),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .fwd_nofwd    (fwd_nofwd),
        .sb_set       (sb_set),
        .sb_set_addr  (sb_set_addr),
        .sb_clr       (sb_clr),
        .sb_clr_addr  (sb_clr_addr),
        .br_id        (br_id),
        .br_hold_vld  (br_hold_vld),
        .br_hold_data (br_hold_data),
        .stallreq     (stallreq),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference state: architectural registers, pending flags, counter, branch capture.
    logic [DW-1:0] m_mem [32];
    logic          m_busy [32];
    logic [CW-1:0] m_cnt;
    logic [NR-1:0] m_hv;
    logic [DW-1:0] m_hd;

    typedef struct packed {
        logic [3:0]  wbe;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [7:0]  fbe;
        logic [9:0]  fa;
        logic [63:0] fd;
        logic [1:0]  nf;
        logic        set;
        logic [4:0]  sa;
        logic        clr;
        logic [4:0]  ca;
        logic        br;
        logic [1:0]  en;
        logic [9:0]  ra;
        logic        chk;
        logic [63:0] xd;
        logic [63:0] xr;
        logic        xs;
        logic        chk_h;
        logic [1:0]  xhv;
        logic [31:0] xhd;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input int first);
        logic [DW-1:0] w;
        if (a == 0) return '0;
        for (int k = first; k < NF; k++) begin
            if (fwd_be[k*4 +: 4] != 0 && fwd_addr[k*AW +: AW] == a) return fwd_data[k*DW +: DW];
        end
        w = m_mem[a];
        if (wb_addr == a) begin
            for (int b = 0; b < 4; b++) if (wb_be[b]) w[b*8 +: 8] = wb_data[b*8 +: 8];
        end
        return w;
    endfunction

    function automatic logic m_stall();
        logic s;
        logic [AW-1:0] a;
        s = 1'b0;
        for (int p = 0; p < NR; p++) begin
            a = rd_addr[p*AW +: AW];
            if (rd_en[p] && a != 0) begin
                for (int k = 0; k < NF; k++) begin
                    if (fwd_be[k*4 +: 4] != 0 && fwd_addr[k*AW +: AW] == a) begin
                        if (fwd_nofwd[k]) s = 1'b1;
                        break;
                    end
                end
                if (m_busy[a] && !(sb_clr && sb_clr_addr == a)) s = 1'b1;
                if (br_id && fwd_be[3:0] != 0 && fwd_addr[AW-1:0] == a) s = 1'b1;
            end
        end
        return s;
    endfunction

    task automatic m_update(input logic st);
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_mem[i]  = '0;
                m_busy[i] = 1'b0;
            end
            m_cnt = '0;
            m_hv  = '0;
            m_hd  = '0;
        end else begin
            if (wb_addr != 0) begin
                for (int b = 0; b < 4; b++) if (wb_be[b]) m_mem[wb_addr][b*8 +: 8] = wb_data[b*8 +: 8];
            end
            if (sb_clr) m_busy[sb_clr_addr] = 1'b0;
            if (sb_set) m_busy[sb_set_addr] = 1'b1;
            m_busy[0] = 1'b0;
            for (int p = 0; p < NR; p++)
                m_hv[p] = br_id && fwd_be[3:0] != 0 && fwd_addr[AW-1:0] == rd_addr[p*AW +: AW];
            m_hd = fwd_data[DW-1:0];
            if (st && m_cnt != '1) m_cnt = m_cnt + 1'b1;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cycle(input bit comb_chk);
        logic [63:0] ed, er;
        logic es;
        #1;
        for (int p = 0; p < NR; p++) begin
            ed[p*DW +: DW] = m_read(rd_addr[p*AW +: AW], 0);
            er[p*DW +: DW] = m_read(rd_addr[p*AW +: AW], 1);
        end
        es = m_stall();
        if (comb_chk) begin
            check("rd_data", rd_data, ed);
            check("rd_raw", rd_raw, er);
            check("stallreq", 64'(stallreq), 64'(es));
        end
        @(posedge clk);
        m_update(es);
        #1;
        check("br_hold_vld", 64'(br_hold_vld), 64'(m_hv));
        check("br_hold_data", 64'(br_hold_data), 64'(m_hd));
        check("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rd_en = '0; rd_addr = '0; wb_be = '0; wb_addr = '0; wb_data = '0;
        fwd_be = '0; fwd_addr = '0; fwd_data = '0; fwd_nofwd = '0;
        sb_set = 0; sb_set_addr = '0; sb_clr = 0; sb_clr_addr = '0; br_id = 0;
    endtask

    task automatic apply(input vec_t v);
        wb_be = v.wbe; wb_addr = v.wa; wb_data = v.wd;
        fwd_be = v.fbe; fwd_addr = v.fa; fwd_data = v.fd; fwd_nofwd = v.nf;
        sb_set = v.set; sb_set_addr = v.sa; sb_clr = v.clr; sb_clr_addr = v.ca;
        br_id = v.br; rd_en = v.en; rd_addr = v.ra;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_mem[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_cnt = '0; m_hv = '0; m_hd = '0;

        for (int i = 0; i < 18; i++) tbl[i] = '0;
        tbl[0].wbe = 4'hF; tbl[0].wa = 5'd3; tbl[0].wd = 32'h1234_5678; tbl[0].chk = 1;
        tbl[1].en = 2'b11; tbl[1].ra = {5'd3, 5'd3}; tbl[1].chk = 1;
        tbl[1].xd = {2{32'h1234_5678}}; tbl[1].xr = {2{32'h1234_5678}};
        tbl[2].wbe = 4'hF; tbl[2].wa = 5'd5; tbl[2].wd = 32'hAAAA_AAAA;
        tbl[3].wbe = 4'b0101; tbl[3].wa = 5'd5; tbl[3].wd = 32'h1122_3344;
        tbl[3].en = 2'b11; tbl[3].ra = {5'd5, 5'd5}; tbl[3].chk = 1;
        tbl[3].xd = {2{32'hAA22_AA44}}; tbl[3].xr = {2{32'hAA22_AA44}};
        tbl[4].en = 2'b11; tbl[4].ra = {5'd5, 5'd5}; tbl[4].chk = 1;
        tbl[4].xd = {2{32'hAA22_AA44}}; tbl[4].xr = {2{32'hAA22_AA44}};
        for (int i = 5; i <= 6; i++) begin
            tbl[i].fbe = 8'hFF; tbl[i].fa = {5'd7, 5'd7}; tbl[i].fd = {32'd2, 32'd1};
            tbl[i].en = 2'b11; tbl[i].ra = {5'd3, 5'd7}; tbl[i].chk = 1;
            tbl[i].xd = {32'h1234_5678, 32'd1}; tbl[i].xr = {32'h1234_5678, 32'd2};
        end
        tbl[6].nf = 2'b01; tbl[6].xs = 1;
        tbl[7].set = 1; tbl[7].sa = 5'd9; tbl[7].chk = 1;
        tbl[8].en = 2'b01; tbl[8].ra = {5'd0, 5'd9}; tbl[8].chk = 1; tbl[8].xs = 1;
        tbl[9].clr = 1; tbl[9].ca = 5'd9; tbl[9].wbe = 4'hF; tbl[9].wa = 5'd9; tbl[9].wd = 32'h55;
        tbl[9].en = 2'b01; tbl[9].ra = {5'd0, 5'd9}; tbl[9].chk = 1;
        tbl[9].xd = 64'h55; tbl[9].xr = 64'h55;
        tbl[10].set = 1; tbl[10].sa = 5'd9;
        tbl[11].set = 1; tbl[11].sa = 5'd9; tbl[11].clr = 1; tbl[11].ca = 5'd9;
        for (int i = 11; i <= 14; i++) begin
            tbl[i].en = 2'b01; tbl[i].ra = {5'd0, 5'd9}; tbl[i].chk = 1;
            tbl[i].xd = 64'h55; tbl[i].xr = 64'h55;
        end
        tbl[12].xs = 1;
        tbl[13].clr = 1; tbl[13].ca = 5'd9;
        tbl[15].br = 1; tbl[15].fbe = 8'h0F; tbl[15].fa = {5'd0, 5'd4};
        tbl[15].fd = {32'd0, 32'hDEAD_BEEF}; tbl[15].en = 2'b10; tbl[15].ra = {5'd4, 5'd0};
        tbl[15].chk = 1; tbl[15].xd = {32'hDEAD_BEEF, 32'd0}; tbl[15].xs = 1;
        tbl[15].chk_h = 1; tbl[15].xhv = 2'b10; tbl[15].xhd = 32'hDEAD_BEEF;
        tbl[16].chk = 1; tbl[16].chk_h = 1;
        tbl[17].fbe = 8'h0F; tbl[17].fa = '0; tbl[17].fd = 64'h77; tbl[17].nf = 2'b01;
        tbl[17].en = 2'b11; tbl[17].chk = 1;

        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        cycle(0);
        cycle(0);
        rst_n = 1'b1;

        rd_en = 2'b11; rd_addr = {5'd3, 5'd31};
        #1;
        check("reset_rd_data", rd_data, 64'd0);
        check("reset_stallreq", 64'(stallreq), 64'd0);
        check("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        check("reset_hold", {30'd0, br_hold_vld, br_hold_data}, 64'd0);
        cycle(1);

        for (int i = 0; i < 18; i++) begin
            apply(tbl[i]);
            if (tbl[i].chk) begin
                #1;
                check($sformatf("vec%0d_rd_data", i), rd_data, tbl[i].xd);
                check($sformatf("vec%0d_rd_raw", i), rd_raw, tbl[i].xr);
                check($sformatf("vec%0d_stallreq", i), 64'(stallreq), 64'(tbl[i].xs));
            end
            cycle(0);
            if (tbl[i].chk_h) begin
                check($sformatf("vec%0d_hold_vld", i), 64'(br_hold_vld), 64'(tbl[i].xhv));
                check($sformatf("vec%0d_hold_data", i), 64'(br_hold_data), 64'(tbl[i].xhd));
            end
        end

        // Counter saturation under a long scoreboard stall.
        idle_inputs();
        sb_set = 1; sb_set_addr = 5'd10;
        cycle(1);
        sb_set = 0; rd_en = 2'b01; rd_addr = {5'd0, 5'd10};
        repeat ((1 << CW) + 3) cycle(1);
        check("stall_cnt_saturated", 64'(stall_cnt), 64'(8'hFF));

        // Reset while stalled and while another register is being marked pending.
        rst_n = 1'b0; sb_set = 1; sb_set_addr = 5'd11;
        cycle(1);
        check("stall_cnt_after_reset", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1; sb_set = 0; rd_en = 2'b11; rd_addr = {5'd11, 5'd10};
        #1;
        check("busy_after_reset", 64'(stallreq), 64'd0);
        rd_addr = {5'd5, 5'd3};
        #1;
        check("storage_after_reset", rd_data, 64'd0);
        cycle(1);

        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            rd_en = 2'($urandom);
            rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wb_be = ($urandom_range(0, 2) != 0) ? 4'($urandom) : 4'h0;
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            for (int k = 0; k < NF; k++) begin
                fwd_be[k*4 +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
                fwd_addr[k*AW +: AW] = 5'($urandom_range(0, 7));
                fwd_data[k*DW +: DW] = $urandom;
                fwd_nofwd[k] = ($urandom_range(0, 3) == 0);
            end
            sb_set = ($urandom_range(0, 3) == 0);
            sb_set_addr = 5'($urandom_range(0, 7));
            sb_clr = ($urandom_range(0, 2) == 0);
            sb_clr_addr = ($urandom_range(0, 3) == 0) ? sb_set_addr : 5'($urandom_range(0, 7));
            br_id = ($urandom_range(0, 4) == 0);
            cycle(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
